// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multicycle multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdu_state_t;

    // Widest operand the abs_w helper can handle.
    localparam int unsigned MDU_MAX_W = 64;

    // Magnitude of a w-bit two's-complement value held in the low bits of v.
    // The result is zero above bit w-1; for the most negative value the
    // magnitude 2^(w-1) is returned, which still fits in w unsigned bits.
    function automatic logic [MDU_MAX_W-1:0] abs_w(input logic [MDU_MAX_W-1:0] v,
                                                   input int unsigned          w);
        logic [MDU_MAX_W-1:0] mask;
        logic [MDU_MAX_W-1:0] mag;
        logic [MDU_MAX_W-1:0] sign_bit;
        mask     = (w >= MDU_MAX_W) ? '1 : ((MDU_MAX_W'(1) << w) - MDU_MAX_W'(1));
        sign_bit = MDU_MAX_W'(1) << (w - 1);
        mag      = v & mask;
        if ((mag & sign_bit) != '0) begin
            mag = (~mag + MDU_MAX_W'(1)) & mask;
        end
        return mag;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide share one 2*WIDTH-bit accumulator
// and one iteration counter; a final FIX cycle applies signs and writes hi/lo.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    mdu_state_t           state;
    mdu_op_t              op_q;
    logic                 neg_res;
    logic                 neg_dvd;
    logic                 dz_pend;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     operand;
    logic [CW-1:0]        cnt;

    mdu_op_t              op_in;
    logic                 is_signed;
    logic                 is_div;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_ext;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_diff;
    logic [2*WIDTH-1:0]   div_next;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Operand decode and magnitude extraction for an incoming request.
    always_comb begin
        op_in     = mdu_op_t'(op);
        is_signed = (op_in == MDU_MULT) || (op_in == MDU_DIV);
        is_div    = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = is_signed ? WIDTH'(abs_w(MDU_MAX_W'(a), WIDTH)) : a;
        b_mag     = is_signed ? WIDTH'(abs_w(MDU_MAX_W'(b), WIDTH)) : b;
    end

    // One shift-add step and one restoring-division step on the accumulator.
    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

        rem_ext  = acc[2*WIDTH-1:WIDTH-1];
        rem_ge   = rem_ext >= {1'b0, operand};
        rem_diff = rem_ext[WIDTH-1:0] - operand;
        div_next = rem_ge ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                          : {rem_ext[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // Sign correction applied in the FIX cycle.
    always_comb begin
        prod_fix = neg_res ? (~acc + (2*WIDTH)'(1)) : acc;
        quo_fix  = neg_res ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
        rem_fix  = neg_dvd ? (~acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM, datapath registers and result write-back.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= MDU_MULT;
            neg_res     <= 1'b0;
            neg_dvd     <= 1'b0;
            dz_pend     <= 1'b0;
            acc         <= '0;
            operand     <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q        <= op_in;
                        neg_res     <= a_neg ^ b_neg;
                        neg_dvd     <= a_neg;
                        cnt         <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
                        if (is_div && (b == '0)) begin
                            // Keep the raw dividend so FIX can return it untouched.
                            dz_pend <= 1'b1;
                            acc     <= {{WIDTH{1'b0}}, a};
                            operand <= '0;
                            state   <= FIX;
                        end else if (is_div) begin
                            dz_pend <= 1'b0;
                            acc     <= {{WIDTH{1'b0}}, a_mag};
                            operand <= b_mag;
                            state   <= DIV;
                        end else begin
                            dz_pend <= 1'b0;
                            acc     <= {{WIDTH{1'b0}}, b_mag};
                            operand <= a_mag;
                            state   <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (dz_pend) begin
                        hi          <= acc[WIDTH-1:0];
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if ((op_q == MDU_DIV) || (op_q == MDU_DIVU)) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Busy covers every non-idle cycle, including FIX.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        use8;
    logic [1:0]  op;
    logic [31:0] a_bus;
    logic [31:0] b_bus;

    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    logic        cur_busy, cur_done, cur_dz;
    logic [31:0] cur_hi, cur_lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) u_dut32 (
        .Clk(clk), .reset(reset), .start(start & ~use8), .op(op),
        .a(a_bus), .b(b_bus), .busy(busy32), .done(done32),
        .hi(hi32), .lo(lo32), .div_by_zero(dz32)
    );

    mult_div_unit #(.WIDTH(8)) u_dut8 (
        .Clk(clk), .reset(reset), .start(start & use8), .op(op),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .busy(busy8), .done(done8),
        .hi(hi8), .lo(lo8), .div_by_zero(dz8)
    );

    // Present the selected instance's outputs on common signals.
    always_comb begin
        cur_busy = use8 ? busy8 : busy32;
        cur_done = use8 ? done8 : done32;
        cur_dz   = use8 ? dz8   : dz32;
        cur_hi   = use8 ? {24'b0, hi8} : hi32;
        cur_lo   = use8 ? {24'b0, lo8} : lo32;
    end

    typedef struct {
        bit          w8;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit w8, logic [1:0] o, logic [31:0] av, logic [31:0] bv,
                                logic [31:0] h, logic [31:0] l, logic dz, string n);
        vec_t v;
        v.w8 = w8; v.op = o; v.a = av; v.b = bv;
        v.hi = h; v.lo = l; v.dz = dz; v.name = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (w%0d): got %h expected %h", name, use8 ? 8 : 32, act, exp);
        end
    endtask

    function automatic int width_now();
        return use8 ? 8 : 32;
    endfunction

    // Issue one operation, then check latency, busy span, hold of hi/lo and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input string name);
        int          k;
        int          busy_n;
        int          lat;
        logic        stable;
        logic [31:0] hi0, lo0;
        logic        bzero;
        bzero = use8 ? (bv[7:0] == 8'h00) : (bv == 32'h0);
        lat   = (o[1] && bzero) ? 2 : width_now() + 2;
        @(negedge clk);
        hi0 = cur_hi; lo0 = cur_lo;
        op = o; a_bus = av; b_bus = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1; busy_n = 0; stable = 1'b1;
        while (!cur_done && k < 200) begin
            if (cur_busy) busy_n++;
            if (cur_hi !== hi0 || cur_lo !== lo0) stable = 1'b0;
            @(negedge clk);
            k++;
        end
        check({name, "_latency"}, 32'(k), 32'(lat));
        check({name, "_busycyc"}, 32'(busy_n), 32'(lat - 1));
        check({name, "_hold"}, 32'(stable), 32'd1);
        check({name, "_busy_at_done"}, 32'(cur_busy), 32'd0);
        check({name, "_hi"}, cur_hi, eh);
        check({name, "_lo"}, cur_lo, el);
        check({name, "_dz"}, 32'(cur_dz), 32'(edz));
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(cur_done), 32'd0);
    endtask

    initial begin
        int k;
        int w;
        int done_n;
        logic [31:0] m;

        reset = 1'b1; start = 1'b0; use8 = 1'b0; op = 2'd0; a_bus = '0; b_bus = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            use8 = (s == 1);
            #1;
            check("rst_busy", 32'(cur_busy), 32'd0);
            check("rst_done", 32'(cur_done), 32'd0);
            check("rst_dz", 32'(cur_dz), 32'd0);
            check("rst_hi", cur_hi, 32'd0);
            check("rst_lo", cur_lo, 32'd0);
        end
        reset = 1'b0;

        vecs.push_back(mk(0, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"));
        vecs.push_back(mk(0, 2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg"));
        vecs.push_back(mk(0, 2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minmin"));
        vecs.push_back(mk(0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, "mult_m1m1"));
        vecs.push_back(mk(0, 2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg"));
        vecs.push_back(mk(0, 2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_negdiv"));
        vecs.push_back(mk(0, 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7"));
        vecs.push_back(mk(0, 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_ovf"));
        vecs.push_back(mk(0, 2'd3, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 1'b1, "divu_zero"));
        vecs.push_back(mk(0, 2'd2, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, "div_zero"));
        vecs.push_back(mk(1, 2'd1, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0, "multu_max"));
        vecs.push_back(mk(1, 2'd0, 32'hFD, 32'h07, 32'hFF, 32'hEB, 1'b0, "mult_neg"));
        vecs.push_back(mk(1, 2'd0, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, "mult_minmin"));
        vecs.push_back(mk(1, 2'd2, 32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0, "div_neg"));
        vecs.push_back(mk(1, 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7"));
        vecs.push_back(mk(1, 2'd2, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, "div_ovf"));
        vecs.push_back(mk(1, 2'd3, 32'h34, 32'h00, 32'h34, 32'hFF, 1'b1, "divu_zero"));

        foreach (vecs[i]) begin
            use8 = vecs[i].w8;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].name);
        end

        for (int s = 0; s < 2; s++) begin
            use8 = (s == 1);
            w = width_now();
            m = use8 ? 32'hFF : 32'hFFFFFFFF;

            // Start pulsed mid-operation with other operands is ignored.
            @(negedge clk);
            op = 2'd1; a_bus = 32'd3; b_bus = 32'd5; start = 1'b1;
            @(negedge clk);
            start = 1'b0; k = 1;
            repeat (3) begin @(negedge clk); k++; end
            op = 2'd3; a_bus = 32'd2; b_bus = 32'd2; start = 1'b1;
            @(negedge clk); k++;
            start = 1'b0; a_bus = 32'd9; b_bus = 32'd9;
            while (!cur_done && k < 200) begin @(negedge clk); k++; end
            check("midstart_latency", 32'(k), 32'(w + 2));
            check("midstart_hi", cur_hi, 32'd0);
            check("midstart_lo", cur_lo, 32'd15);
            @(negedge clk);
            check("midstart_no_second", 32'(cur_busy), 32'd0);

            // Start held through the done cycle issues a second operation there.
            op = 2'd1; a_bus = 32'd3; b_bus = 32'd5; start = 1'b1;
            @(negedge clk);
            a_bus = 32'd6; b_bus = 32'd7; k = 1;
            while (!cur_done && k < 200) begin @(negedge clk); k++; end
            check("held_first_latency", 32'(k), 32'(w + 2));
            check("held_first_lo", cur_lo, 32'd15);
            @(negedge clk);
            start = 1'b0; k = 1;
            check("held_second_busy", 32'(cur_busy), 32'd1);
            while (!cur_done && k < 200) begin @(negedge clk); k++; end
            check("held_second_latency", 32'(k), 32'(w + 2));
            check("held_second_hi", cur_hi, 32'd0);
            check("held_second_lo", cur_lo, 32'd42);
            @(negedge clk);

            // div_by_zero holds after done and clears on the next accepted start.
            run_op(2'd3, 32'h34, 32'h0, 32'h34, m, 1'b1, "dz_set");
            check("dz_held", 32'(cur_dz), 32'd1);
            op = 2'd1; a_bus = 32'd2; b_bus = 32'd3; start = 1'b1;
            @(negedge clk);
            start = 1'b0; k = 1;
            check("dz_cleared", 32'(cur_dz), 32'd0);
            while (!cur_done && k < 200) begin @(negedge clk); k++; end
            check("dz_next_latency", 32'(k), 32'(w + 2));
            check("dz_next_lo", cur_lo, 32'd6);
            @(negedge clk);

            // Reset in cycle T+10 aborts the operation without a done.
            check("pre_reset_lo_nonzero", 32'(cur_lo != 32'd0), 32'd1);
            op = 2'd0; a_bus = 32'hFFFFFFFD; b_bus = 32'd7; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 1; c < 10; c++) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("abort_busy", 32'(cur_busy), 32'd0);
            check("abort_done", 32'(cur_done), 32'd0);
            check("abort_hi", cur_hi, 32'd0);
            check("abort_lo", cur_lo, 32'd0);
            reset = 1'b0;
            done_n = 0;
            repeat (40) begin
                @(negedge clk);
                if (cur_done || cur_busy) done_n++;
            end
            check("abort_no_done", 32'(done_n), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised multicycle multiply/divide unit with HI/LO result registers, the successor to the ALU's fixed 32-bit multiplier. It adds MULTU, DIV and DIVU alongside MULT. It replaces the workMult/endMult pair with a start/busy/done handshake. The control FSM issues one operation, stalls on busy, and reads hi/lo through the ALUOut mux for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits; legal values are even and at least 4

Ports:
Clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only while busy=0
op  in  2  operation: 0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU
a  in  WIDTH  multiplicand or dividend
b  in  WIDTH  multiplier or divisor
busy  out  1  operation in progress; start is ignored while high
done  out  1  one-cycle pulse; hi/lo are valid from this cycle
hi  out  WIDTH  product[2W-1:W], or remainder
lo  out  WIDTH  product[W-1:0], or quotient
div_by_zero  out  1  set with done when the last DIV/DIVU had b=0; held until the next accepted start

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM in IDLE. Reset wins over all other inputs.
- FSM states:
  - IDLE
  - MUL: shift-add, one partial product per cycle
  - DIV: restoring division, one quotient bit per cycle
  - FIX: sign correction and hi/lo write
- Accept: start=1 and busy=0 in cycle T.
  - Latch magnitudes of a and b. For signed ops take two's-complement absolute values.
  - Latch op, sign of result and sign of dividend.
  - Load iteration counter = WIDTH. Clear div_by_zero.
- Latency: busy=1 in cycles T+1 .. T+WIDTH+1. MUL/DIV iterate for WIDTH cycles, then FIX for one cycle. In cycle T+WIDTH+2, done=1, busy=0 and hi/lo hold the new result.
- hi/lo change only at the FIX→IDLE edge and otherwise hold indefinitely. Intermediate values are never visible on hi/lo.
- A start asserted in the done cycle is accepted; back-to-back issue costs WIDTH+2 cycles per operation.
- Start while busy: ignored, not queued. op, a and b changes while busy have no effect.
- Multiply arithmetic:
  - Full 2W-bit product.
  - MULT negates the 2W-bit magnitude product when sign(a) XOR sign(b).
  - MULTU treats both operands as unsigned.
- Divide arithmetic:
  - Quotient truncates toward zero; remainder takes the sign of the dividend, so a = q*b + r.
  - DIV with a = -2^(W-1) and b = -1 gives lo = -2^(W-1) and hi = 0. This is not flagged.
- Divide by zero (DIV/DIVU with b=0): skip iteration and go straight to FIX.
  - done=1 at T+2.
  - hi = a unmodified; lo = all ones.
  - div_by_zero=1.
- A counter decrement at 0 is not reachable. The FSM leaves MUL/DIV when the counter reaches 1 after its decrement, giving exactly WIDTH iterations.
- Reset mid-operation: abort immediately. All outputs return to reset values and no done is issued.

Decomposition:
- Package mdu_pkg:
  - enum mdu_op_t {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}, 2 bits
  - enum mdu_state_t {IDLE, MUL, DIV, FIX}
  - function abs_w (magnitude of a signed WIDTH value)
- Single module; no sub-module. The multiply and divide datapaths share one 2W-bit accumulator/remainder register and the iteration counter.

Test Plan:
- MULTU, WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the start cycle; busy high for 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 → lo=14, hi=2; DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → done at T+2, hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1; the next MULTU start clears div_by_zero in the cycle after accept.
- Handshake:
  - start pulsed mid-operation with different operands → ignored; the first result is unchanged.
  - start held high through the done cycle → second op accepted there; its done arrives 34 cycles later.
- reset at cycle T+10 of a MULT → busy=0, done=0, hi=lo=0 the next cycle; no done pulse follows. Repeat all checks with WIDTH=8 (MULTU 0xFF×0xFF → hi=0xFE, lo=0x01, done at T+10).
